// File: rtl/countdown_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_bcd
// Description : BCD MM:SS.CC countdown timer. A prescaler produces one tick
//               every TICK_DIV cycles; each tick decrements the loaded value
//               by one centisecond through a per-digit ripple-borrow chain.
//               An IDLE/RUN/PAUSE/DONE state machine provides start, pause,
//               resume and expiry signalling.
//               Optional feature macro: COUNTDOWN_ALARM_EN adds an alarm
//               output that stays high for ALARM_TICKS ticks after expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_bcd #(
    parameter int TICK_DIV    = 100000
`ifdef COUNTDOWN_ALARM_EN
   ,parameter int ALARM_TICKS = 100
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic [7:0] load_csec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic [7:0] csec_out,
    output logic       running,
    output logic       done,
    output logic       expired
`ifdef COUNTDOWN_ALARM_EN
   ,output logic       alarm
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] C_PRESC_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Borrowing decrement of one BCD digit: returns {borrow_out, new_digit}.
    // A digit only moves when a borrow arrives; at zero it wraps to wrap_to.
    function automatic logic [4:0] dec_digit(input logic [3:0] d,
                                             input logic       b,
                                             input logic [3:0] wrap_to);
        logic [4:0] r;
        if (!b) begin
            r = {1'b0, d};
        end else if (d == 4'd0) begin
            r = {1'b1, wrap_to};
        end else begin
            r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

    // Clamp an out-of-range BCD digit to the largest legal value.
    function automatic logic [3:0] sat_digit(input logic [3:0] d,
                                             input logic [3:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      sec_q, sec_d;
    logic [7:0]      csec_q, csec_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;

    logic [4:0]      w_cu, w_ct, w_su, w_st, w_mu, w_mt;
    logic [23:0]     w_dec_val;
    logic            w_val_zero;
    logic            w_dec_zero;
    logic            w_presc_wrap;
    logic [PW-1:0]   w_presc_next;

`ifdef COUNTDOWN_ALARM_EN
    localparam int AW = $clog2(ALARM_TICKS + 2);
    localparam logic [AW-1:0] C_ALARM_LEN = AW'(ALARM_TICKS);
    localparam logic [AW-1:0] C_ALARM_ONE = AW'(1);

    logic            alarm_q, alarm_d;
    logic [AW-1:0]   alarm_cnt_q, alarm_cnt_d;
`endif

    // Ripple-borrow chain over all six digits, always fed a borrow of one.
    always_comb begin
        w_cu = dec_digit(csec_q[3:0], 1'b1,     4'd9);
        w_ct = dec_digit(csec_q[7:4], w_cu[4],  4'd9);
        w_su = dec_digit(sec_q[3:0],  w_ct[4],  4'd9);
        w_st = dec_digit(sec_q[7:4],  w_su[4],  4'd5);
        w_mu = dec_digit(min_q[3:0],  w_st[4],  4'd9);
        w_mt = dec_digit(min_q[7:4],  w_mu[4],  4'd9);
        w_dec_val    = {w_mt[3:0], w_mu[3:0], w_st[3:0], w_su[3:0],
                        w_ct[3:0], w_cu[3:0]};
        w_val_zero   = ({min_q, sec_q, csec_q} == 24'd0);
        w_dec_zero   = (w_dec_val == 24'd0);
        w_presc_wrap = (presc_q == C_PRESC_MAX);
        w_presc_next = w_presc_wrap ? '0 : (presc_q + C_PRESC_ONE);
    end

    // Next-state, prescaler and digit update; load overrides everything else.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        csec_d  = csec_q;
        presc_d = presc_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_ALARM_EN
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
`endif
        if (load) begin
            min_d   = {sat_digit(load_min[7:4],  4'd9), sat_digit(load_min[3:0],  4'd9)};
            sec_d   = {sat_digit(load_sec[7:4],  4'd5), sat_digit(load_sec[3:0],  4'd9)};
            csec_d  = {sat_digit(load_csec[7:4], 4'd9), sat_digit(load_csec[3:0], 4'd9)};
            state_d = S_IDLE;
            presc_d = '0;
`ifdef COUNTDOWN_ALARM_EN
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    // stop beats start; stop itself does nothing here.
                    if (start && !stop) begin
                        if (w_val_zero) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            presc_d = '0;
`ifdef COUNTDOWN_ALARM_EN
                            alarm_d     = (ALARM_TICKS > 0);
                            alarm_cnt_d = C_ALARM_LEN;
`endif
                        end else begin
                            state_d = S_RUN;
                            if (state_q == S_IDLE) begin
                                presc_d = '0;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        // Freeze both value and prescaler so resume loses nothing.
                        state_d = S_PAUSE;
                    end else begin
                        presc_d = w_presc_next;
                        if (w_presc_wrap) begin
                            {min_d, sec_d, csec_d} = w_dec_val;
                            if (w_dec_zero) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
`ifdef COUNTDOWN_ALARM_EN
                                alarm_d     = (ALARM_TICKS > 0);
                                alarm_cnt_d = C_ALARM_LEN;
`endif
                            end
                        end
                    end
                end
                S_DONE: begin
`ifdef COUNTDOWN_ALARM_EN
                    // The prescaler only runs here to time the alarm pulse.
                    if (alarm_q) begin
                        presc_d = w_presc_next;
                        if (w_presc_wrap) begin
                            if (alarm_cnt_q <= C_ALARM_ONE) begin
                                alarm_d     = 1'b0;
                                alarm_cnt_d = '0;
                            end else begin
                                alarm_cnt_d = alarm_cnt_q - C_ALARM_ONE;
                            end
                        end
                    end
`endif
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, digit, prescaler and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            csec_q  <= 8'h00;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            csec_q  <= csec_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    // Alarm pulse and its tick counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign min_out  = min_q;
    assign sec_out  = sec_q;
    assign csec_out = csec_q;
    assign running  = (state_q == S_RUN);
    assign expired  = (state_q == S_DONE);
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer_bcd
// Description : Directed self-checking bench for countdown_timer_bcd with
//               TICK_DIV=4. Alarm checks are built when COUNTDOWN_ALARM_EN
//               is defined (ALARM_TICKS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_bcd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;
    logic [7:0] load_csec = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] min_out, sec_out, csec_out;
    logic       running, done, expired;
`ifdef COUNTDOWN_ALARM_EN
    logic       alarm;
`endif

    int checks = 0;
    int errors = 0;

    countdown_timer_bcd #(
        .TICK_DIV    (4)
`ifdef COUNTDOWN_ALARM_EN
       ,.ALARM_TICKS (3)
`endif
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .load_csec (load_csec),
        .start     (start),
        .stop      (stop),
        .min_out   (min_out),
        .sec_out   (sec_out),
        .csec_out  (csec_out),
        .running   (running),
        .done      (done),
        .expired   (expired)
`ifdef COUNTDOWN_ALARM_EN
       ,.alarm     (alarm)
`endif
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1ns later.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] val();
        return {8'h00, min_out, sec_out, csec_out};
    endfunction

    task automatic do_load(input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
        load = 1'b1; load_min = m; load_sec = s; load_csec = c;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        reset = 1'b0;
        check_eq("rst_val",     val(),   32'h000000);
        check_eq("rst_running", running, 0);
        check_eq("rst_done",    done,    0);
        check_eq("rst_expired", expired, 0);

        // Basic count 00:00.03 -> zero
        do_load(8'h00, 8'h00, 8'h03);
        check_eq("ld_val", val(), 32'h000003);
        do_start();                         // edge E0
        check_eq("run_after_start", running, 1);
        cyc(3);
        check_eq("no_dec_E3", val(), 32'h000003);
        cyc(1);
        check_eq("dec_E4", val(), 32'h000002);
        cyc(4);
        check_eq("dec_E8", val(), 32'h000001);
        cyc(3);
        check_eq("pre_zero_done", done, 0);
        cyc(1);
        check_eq("zero_val",  val(),   32'h000000);
        check_eq("zero_done", done,    1);
        check_eq("zero_exp",  expired, 1);
        check_eq("zero_run",  running, 0);
        cyc(1);
        check_eq("done_pulse_end", done,    0);
        check_eq("exp_hold",       expired, 1);
        do_start();
        check_eq("start_in_done_ign", expired, 1);
        check_eq("start_in_done_run", running, 0);
        check_eq("done_val_hold",     val(),   32'h000000);

        // Borrow chains
        do_load(8'h01, 8'h00, 8'h00);
        do_start();
        cyc(4);
        check_eq("borrow_min_units", val(), 32'h005999);
        do_load(8'h10, 8'h00, 8'h00);
        do_start();
        cyc(4);
        check_eq("borrow_min_tens", val(), 32'h095999);
        do_load(8'h00, 8'h10, 8'h00);
        do_start();
        cyc(4);
        check_eq("borrow_sec_tens", val(), 32'h000999);

        // Pause and resume
        do_load(8'h00, 8'h00, 8'h05);
        do_start();                         // E0
        cyc(2);
        stop = 1'b1;
        cyc(1);                             // stop edge E0+3
        stop = 1'b0;
        check_eq("pause_run", running, 0);
        check_eq("pause_val0", val(), 32'h000005);
        cyc(10);
        check_eq("pause_val10", val(), 32'h000005);
        check_eq("pause_run10", running, 0);
        do_start();                         // resume edge Er
        check_eq("resume_run", running, 1);
        cyc(1);
        check_eq("resume_Er1", val(), 32'h000005);
        cyc(1);
        check_eq("resume_Er2", val(), 32'h000004);
        cyc(4);
        check_eq("resume_next", val(), 32'h000003);

        // Saturation
        do_load(8'hA3, 8'h7A, 8'h9F);
        check_eq("saturate", val(), 32'h935999);

        // load + stop + start together while running
        do_start();
        cyc(2);
        load = 1'b1; stop = 1'b1; start = 1'b1;
        load_min = 8'h00; load_sec = 8'h00; load_csec = 8'h07;
        cyc(1);
        load = 1'b0; stop = 1'b0; start = 1'b0;
        check_eq("prio_val", val(),   32'h000007);
        check_eq("prio_run", running, 0);
        check_eq("prio_exp", expired, 0);

        // start + stop together in PAUSE keeps PAUSE
        do_start();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check_eq("pause_ss_run", running, 0);
        check_eq("pause_ss_exp", expired, 0);
        do_start();
        check_eq("pause_resume_ok", running, 1);

        // start on zero value
        do_load(8'h00, 8'h00, 8'h00);
        do_start();
        check_eq("zstart_done", done,    1);
        check_eq("zstart_exp",  expired, 1);
        check_eq("zstart_run",  running, 0);

        // reset in the tick cycle
        do_load(8'h00, 8'h00, 8'h02);
        do_start();
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_eq("rst_tick_val", val(),   32'h000000);
        check_eq("rst_tick_run", running, 0);
        check_eq("rst_tick_exp", expired, 0);
        check_eq("rst_tick_done", done,   0);

        // load in the tick cycle discards the tick
        do_load(8'h00, 8'h00, 8'h02);
        do_start();
        cyc(3);
        do_load(8'h00, 8'h00, 8'h09);
        check_eq("ld_tick_val", val(),   32'h000009);
        check_eq("ld_tick_run", running, 0);

`ifdef COUNTDOWN_ALARM_EN
        do_load(8'h00, 8'h00, 8'h01);
        check_eq("alarm_idle", alarm, 0);
        do_start();
        cyc(4);
        check_eq("alarm_done",  done,  1);
        check_eq("alarm_rise",  alarm, 1);
        cyc(11);
        check_eq("alarm_hold11", alarm, 1);
        cyc(1);
        check_eq("alarm_fall12", alarm, 0);
        do_load(8'h00, 8'h00, 8'h01);
        do_start();
        cyc(4);
        cyc(2);
        check_eq("alarm_pre_load", alarm, 1);
        do_load(8'h00, 8'h00, 8'h00);
        check_eq("alarm_load_clr", alarm, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer_bcd.md
# countdown_timer_bcd

BCD countdown timer that decrements a loaded MM:SS.CC value toward 00:00.00 using a per-digit ripple-borrow chain. It is the down-counting counterpart of the stopwatch's ripple-carry incrementer path and sits beside the stopwatch core, driving the same display formatter. It contains a tick prescaler, a run/pause/done state machine and expiry signalling.

## Interface
- TICK_DIV, 100000: clock cycles per centisecond tick; must be ≥ 2.
- ALARM_TICKS, 100: length of the alarm pulse in ticks; used only when COUNTDOWN_ALARM_EN is defined.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  loads load_min/load_sec/load_csec and enters IDLE.
- load_min  in  8  BCD minutes, 00–99.
- load_sec  in  8  BCD seconds, 00–59.
- load_csec  in  8  BCD centiseconds, 00–99.
- start  in  1  begins or resumes counting.
- stop  in  1  pauses counting.
- min_out  out  8  current BCD minutes.
- sec_out  out  8  current BCD seconds.
- csec_out  out  8  current BCD centiseconds.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the count reaches zero.
- expired  out  1  high while in DONE.
- alarm  out  1  present only with COUNTDOWN_ALARM_EN.

## Operation
- Reset values: all digit registers 00, state IDLE, prescaler 0, and running, done, expired and alarm all 0.
- States are IDLE, RUN, PAUSE and DONE.
- Input priority per cycle: reset > load > stop > start.
- load, from any state:
  - Registers the value and goes to IDLE with the prescaler cleared.
  - Each invalid digit saturates independently: units > 9 becomes 9, minute/centisecond tens > 9 becomes 9, second tens > 5 becomes 5.
- start in IDLE or PAUSE:
  - If the value is non-zero, go to RUN; from IDLE the prescaler is cleared, from PAUSE it keeps its held value.
  - If the value is zero, go to DONE and pulse done.
- start in RUN or DONE is ignored.
- stop in RUN goes to PAUSE with the prescaler held. stop in any other state is ignored. When start and stop arrive in the same cycle, stop wins.
- Prescaler in RUN: counts 0..TICK_DIV-1 and wraps. A tick occurs in the cycle where prescaler == TICK_DIV-1.
- On a tick, the value decrements by 1 centisecond. The borrow ripples csec units → csec tens → sec units → sec tens → min units → min tens:
  - Each units digit wraps 0→9 with a borrow.
  - csec tens and min tens wrap 0→9 with a borrow; sec tens wraps 0→5 with a borrow.
  - A digit only decrements when the borrow into it is 1.
- If a tick produces 00:00.00, the state goes to DONE on the same edge and done is high for exactly that cycle.
- In DONE the value holds at zero. Only load or reset leaves DONE.
- The value never underflows below 00:00.00.

## Timing
- All outputs are registered.
- start is accepted at edge E0. The first decrement is visible after edge E0+TICK_DIV, and subsequent decrements follow every TICK_DIV cycles.
- done asserts after the same edge that registers the zero value. expired rises on that edge and stays high.
- start on a zero value: done and expired are high one cycle after the start edge, and running is never high.
- stop at edge Ep freezes the value and prescaler. A later start resumes the remaining prescaler count, so no partial tick is lost or repeated.
- load and reset take effect at the next edge, including mid-RUN and in the exact cycle of a tick; the tick is discarded.
- running mirrors state == RUN with no extra latency.

## Configuration
- COUNTDOWN_ALARM_EN defined:
  - Port alarm exists.
  - alarm rises with the done pulse and stays high for ALARM_TICKS ticks; the prescaler keeps running in DONE to time it.
  - load or reset clears alarm immediately.
- COUNTDOWN_ALARM_EN undefined:
  - No alarm port, no alarm counter, and the prescaler stays idle in DONE.
  - All other behaviour is identical.

## Test plan
- TICK_DIV=4; load 00:00.03 then start at E0 → outputs read 00:00.02 at E0+4 and 00:00.01 at E0+8; at E0+12 they read 00:00.00 with done=1 for one cycle, then expired=1 and running=0.
- Borrow chain: load 01:00.00, start, one tick → 00:59.99; load 10:00.00, one tick → 09:59.99.
- Pause and resume: load 00:00.05, start, stop 2 cycles after E0, hold 10 cycles, start → first decrement 2 cycles after the resume edge, and the value is unchanged during the pause.
- Saturation and priority: load min=0xA3, sec=0x7A, csec=0x9F → 93:59.99. load, stop and start together in RUN → IDLE with the new value. start and stop together in PAUSE → stays PAUSE.
- Boundary cases:
  - start with 00:00.00 → done=1 and expired=1 one cycle later.
  - reset asserted in the tick cycle → all outputs at reset values, with no decrement.
- With COUNTDOWN_ALARM_EN, TICK_DIV=4, ALARM_TICKS=3 → alarm is high for 12 cycles starting with the done cycle; a load during the alarm clears it at the next edge.
